// File: rtl/rx_8b10b_align_decoder_if.sv
// Serial-in / decoded-byte-out bundle for the 8b/10b receive aligner-decoder.
// Latency: n/a (wiring only).
// Backpressure: none; the serial side is qualified by i_Ser_Valid and the byte side is a one-cycle strobe.
//
// Ports carried:
//   i_Ser_Data, i_Ser_Valid, i_Realign              -> into the decoder
//   o_Data[7:0], o_K, o_Data_Valid, o_Code_Err,
//   o_Disp_Err, o_Locked, o_RD                      <- out of the decoder
interface rx_8b10b_align_decoder_if;
   logic       i_Ser_Data;
   logic       i_Ser_Valid;
   logic       i_Realign;
   logic [7:0] o_Data;
   logic       o_K;
   logic       o_Data_Valid;
   logic       o_Code_Err;
   logic       o_Disp_Err;
   logic       o_Locked;
   logic       o_RD;

   // master: the link side that feeds serial bits and consumes bytes
   modport master (
      output i_Ser_Data, i_Ser_Valid, i_Realign,
      input  o_Data, o_K, o_Data_Valid, o_Code_Err, o_Disp_Err, o_Locked, o_RD
   );

   // slave: the decoder itself
   modport slave (
      input  i_Ser_Data, i_Ser_Valid, i_Realign,
      output o_Data, o_K, o_Data_Valid, o_Code_Err, o_Disp_Err, o_Locked, o_RD
   );
endinterface

// File: rtl/rx_8b10b_align_decoder.sv
// Serial 8b/10b receiver: K28.5 comma hunt, word lock, 10b->8b decode with code and RD checks.
// Latency: byte outputs register on the edge that samples the 10th bit of a symbol (strobe visible the next cycle).
// Backpressure: none; bits with i_Ser_Valid low are skipped, the byte side cannot stall.
//
// Ports:
//   i_Clk, i_Rst (async, active-high)
//   rx.i_Ser_Data / rx.i_Ser_Valid : serial bit, LSB (bit 0 of the symbol) first
//   rx.i_Realign                   : synchronous return to HUNT, clears all state
//   rx.o_Data {HGF,EDCBA}, rx.o_K, rx.o_Data_Valid, rx.o_Code_Err, rx.o_Disp_Err, rx.o_Locked, rx.o_RD
module rx_8b10b_align_decoder #(
   parameter int LOCK_COMMAS = 2,
   parameter int ERR_LIMIT   = 4
) (
   input logic                      i_Clk,
   input logic                      i_Rst,
   rx_8b10b_align_decoder_if.slave  rx
);

   localparam logic [9:0] K285_M   = 10'b0011111010;
   localparam logic [9:0] K285_P   = 10'b1100000101;
   localparam logic [3:0] LOCK_N   = 4'(LOCK_COMMAS);
   localparam logic [3:0] ERR_N    = 4'(ERR_LIMIT);

   typedef enum logic [1:0] {
      S_HUNT   = 2'd0,
      S_CHECK  = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   state_t     state_q;
   logic [9:0] sr_q;
   logic [3:0] bit_cnt_q;
   logic [3:0] fill_q;      // bits shifted since entering HUNT, saturating at 9
   logic [3:0] comma_cnt_q;
   logic [3:0] err_cnt_q;
   logic       rd_q;
   logic [7:0] data_q;
   logic       k_q;
   logic       dvld_q;
   logic       cerr_q;
   logic       derr_q;
   logic       locked_q;

   // ---------------------------------------------------------------
   // Decode helpers
   // ---------------------------------------------------------------
   // {ok, EDCBA}; the K28 6b codes are deliberately absent, they are only
   // legal as part of a full K28.5 symbol which is matched separately.
   function automatic logic [5:0] dec6(input logic [5:0] c);
      logic [5:0] r;
      case (c)
         6'b100111, 6'b011000: r = {1'b1, 5'd0};
         6'b011101, 6'b100010: r = {1'b1, 5'd1};
         6'b101101, 6'b010010: r = {1'b1, 5'd2};
         6'b110001:            r = {1'b1, 5'd3};
         6'b110101, 6'b001010: r = {1'b1, 5'd4};
         6'b101001:            r = {1'b1, 5'd5};
         6'b011001:            r = {1'b1, 5'd6};
         6'b111000, 6'b000111: r = {1'b1, 5'd7};
         6'b111001, 6'b000110: r = {1'b1, 5'd8};
         6'b100101:            r = {1'b1, 5'd9};
         6'b010101:            r = {1'b1, 5'd10};
         6'b110100:            r = {1'b1, 5'd11};
         6'b001101:            r = {1'b1, 5'd12};
         6'b101100:            r = {1'b1, 5'd13};
         6'b011100:            r = {1'b1, 5'd14};
         6'b010111, 6'b101000: r = {1'b1, 5'd15};
         6'b011011, 6'b100100: r = {1'b1, 5'd16};
         6'b100011:            r = {1'b1, 5'd17};
         6'b010011:            r = {1'b1, 5'd18};
         6'b110010:            r = {1'b1, 5'd19};
         6'b001011:            r = {1'b1, 5'd20};
         6'b101010:            r = {1'b1, 5'd21};
         6'b011010:            r = {1'b1, 5'd22};
         6'b111010, 6'b000101: r = {1'b1, 5'd23};
         6'b110011, 6'b001100: r = {1'b1, 5'd24};
         6'b100110:            r = {1'b1, 5'd25};
         6'b010110:            r = {1'b1, 5'd26};
         6'b110110, 6'b001001: r = {1'b1, 5'd27};
         6'b001110:            r = {1'b1, 5'd28};
         6'b101110, 6'b010001: r = {1'b1, 5'd29};
         6'b011110, 6'b100001: r = {1'b1, 5'd30};
         6'b101011, 6'b010100: r = {1'b1, 5'd31};
         default:              r = 6'd0;
      endcase
      return r;
   endfunction

   // {ok, HGF}; both P7 and A7 forms map to 7.
   function automatic logic [3:0] dec4(input logic [3:0] c);
      logic [3:0] r;
      case (c)
         4'b1011, 4'b0100: r = {1'b1, 3'd0};
         4'b1001:          r = {1'b1, 3'd1};
         4'b0101:          r = {1'b1, 3'd2};
         4'b1100, 4'b0011: r = {1'b1, 3'd3};
         4'b1101, 4'b0010: r = {1'b1, 3'd4};
         4'b1010:          r = {1'b1, 3'd5};
         4'b0110:          r = {1'b1, 3'd6};
         4'b1110, 4'b0001: r = {1'b1, 3'd7};
         4'b0111, 4'b1000: r = {1'b1, 3'd7};
         default:          r = 4'd0;
      endcase
      return r;
   endfunction

   function automatic logic [2:0] ones6(input logic [5:0] v);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 6; i++) n = n + {2'b00, v[i]};
      return n;
   endfunction

   function automatic logic [2:0] ones4(input logic [3:0] v);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 4; i++) n = n + {2'b00, v[i]};
      return n;
   endfunction

   // ---------------------------------------------------------------
   // Candidate symbol and its decode, evaluated every cycle
   // ---------------------------------------------------------------
   logic [9:0] sr_d;
   logic       k_hit;
   logic       k_minus;
   logic [5:0] d6;
   logic [3:0] d4;
   logic [2:0] n6;
   logic [2:0] n4;
   logic       de6;
   logic       de4;
   logic       rd_mid;
   logic       rd_d;
   logic       code_err;
   logic       disp_err;
   logic [7:0] byte_d;

   always_comb begin
      sr_d     = {rx.i_Ser_Data, sr_q[9:1]};
      k_minus  = (sr_d == K285_M);
      k_hit    = k_minus || (sr_d == K285_P);
      d6       = dec6(sr_d[9:4]);
      d4       = dec4(sr_d[3:0]);
      n6       = ones6(sr_d[9:4]);
      n4       = ones4(sr_d[3:0]);
      code_err = !k_hit && !(d6[5] && d4[3]);

      // 6b sub-block against entry RD. Unbalanced counts outside 2..4 are
      // never legal codes; they leave RD alone and show up as code errors only.
      de6    = 1'b0;
      rd_mid = rd_q;
      case (n6)
         3'd4: begin de6 = rd_q;  rd_mid = 1'b1; end
         3'd2: begin de6 = !rd_q; rd_mid = 1'b0; end
         3'd3: de6 = (rd_q && sr_d[9:4] == 6'b111000) || (!rd_q && sr_d[9:4] == 6'b000111);
         default: ;
      endcase

      // 4b sub-block against RD after the 6b block
      de4  = 1'b0;
      rd_d = rd_mid;
      case (n4)
         3'd3: begin de4 = rd_mid;  rd_d = 1'b1; end
         3'd1: begin de4 = !rd_mid; rd_d = 1'b0; end
         3'd2: de4 = (rd_mid && sr_d[3:0] == 4'b1100) || (!rd_mid && sr_d[3:0] == 4'b0011);
         default: ;
      endcase

      disp_err = de6 || de4;

      if (code_err)   byte_d = 8'h00;
      else if (k_hit) byte_d = 8'hBC;
      else            byte_d = {d4[2:0], d6[4:0]};
   end

   // ---------------------------------------------------------------
   // Alignment / lock FSM with registered outputs
   // ---------------------------------------------------------------
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q     <= S_HUNT;
         sr_q        <= '0;
         bit_cnt_q   <= '0;
         fill_q      <= '0;
         comma_cnt_q <= '0;
         err_cnt_q   <= '0;
         rd_q        <= 1'b0;
         data_q      <= '0;
         k_q         <= 1'b0;
         dvld_q      <= 1'b0;
         cerr_q      <= 1'b0;
         derr_q      <= 1'b0;
         locked_q    <= 1'b0;
      end else if (rx.i_Realign) begin
         // Realign beats any symbol completing this cycle: nothing is emitted.
         state_q     <= S_HUNT;
         sr_q        <= '0;
         bit_cnt_q   <= '0;
         fill_q      <= '0;
         comma_cnt_q <= '0;
         err_cnt_q   <= '0;
         rd_q        <= 1'b0;
         data_q      <= '0;
         k_q         <= 1'b0;
         dvld_q      <= 1'b0;
         cerr_q      <= 1'b0;
         derr_q      <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         dvld_q <= 1'b0;
         if (rx.i_Ser_Valid) begin
            sr_q <= sr_d;
            case (state_q)
               S_HUNT: begin
                  if (fill_q != 4'd9) fill_q <= fill_q + 4'd1;
                  // fill_q == 9 means this bit completes at least 10 fresh bits
                  if (fill_q == 4'd9 && k_hit) begin
                     bit_cnt_q   <= '0;
                     rd_q        <= k_minus;
                     comma_cnt_q <= 4'd1;
                     err_cnt_q   <= '0;
                     if (LOCK_N == 4'd1) begin
                        state_q  <= S_LOCKED;
                        locked_q <= 1'b1;
                        data_q   <= 8'hBC;
                        k_q      <= 1'b1;
                        cerr_q   <= 1'b0;
                        derr_q   <= 1'b0;
                        dvld_q   <= 1'b1;
                     end else begin
                        state_q  <= S_CHECK;
                     end
                  end
               end

               S_CHECK: begin
                  bit_cnt_q <= (bit_cnt_q == 4'd9) ? 4'd0 : bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd9) begin
                     if (k_hit) begin
                        // While acquiring, every comma re-seeds RD from its own
                        // form, so a run of same-form commas still builds lock.
                        rd_q        <= k_minus;
                        comma_cnt_q <= comma_cnt_q + 4'd1;
                        if (comma_cnt_q + 4'd1 == LOCK_N) begin
                           state_q  <= S_LOCKED;
                           locked_q <= 1'b1;
                           data_q   <= 8'hBC;
                           k_q      <= 1'b1;
                           cerr_q   <= 1'b0;
                           derr_q   <= 1'b0;
                           dvld_q   <= 1'b1;
                        end
                     end else if (code_err || disp_err) begin
                        rd_q    <= rd_d;
                        state_q <= S_HUNT;
                        fill_q  <= '0;
                     end else begin
                        rd_q    <= rd_d;
                     end
                  end
               end

               S_LOCKED: begin
                  bit_cnt_q <= (bit_cnt_q == 4'd9) ? 4'd0 : bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd9) begin
                     rd_q   <= rd_d;
                     data_q <= byte_d;
                     k_q    <= k_hit;
                     cerr_q <= code_err;
                     derr_q <= disp_err;
                     dvld_q <= 1'b1;
                     if (code_err || disp_err) begin
                        if (err_cnt_q + 4'd1 == ERR_N) begin
                           state_q   <= S_HUNT;
                           locked_q  <= 1'b0;
                           fill_q    <= '0;
                           err_cnt_q <= '0;
                        end else begin
                           err_cnt_q <= err_cnt_q + 4'd1;
                        end
                     end else begin
                        err_cnt_q <= '0;
                     end
                  end
               end

               default: begin
                  state_q  <= S_HUNT;
                  fill_q   <= '0;
                  locked_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign rx.o_Data       = data_q;
   assign rx.o_K          = k_q;
   assign rx.o_Data_Valid = dvld_q;
   assign rx.o_Code_Err   = cerr_q;
   assign rx.o_Disp_Err   = derr_q;
   assign rx.o_Locked     = locked_q;
   assign rx.o_RD         = rd_q;

endmodule

// File: tb/tb_rx_8b10b_align_decoder.sv
// Directed bench for the 8b/10b receive aligner-decoder.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: n/a; serial stimulus may insert invalid gap cycles.
module tb_rx_8b10b_align_decoder;

   localparam logic [9:0] KM  = 10'b0011111010; // K28.5, RD- form
   localparam logic [9:0] D0P = 10'b0110001011; // D0.0, RD+ form
   localparam logic [9:0] D0M = 10'b1001110100; // D0.0, RD- form
   localparam logic [9:0] BAD = 10'b1111111111;

   logic clk;
   logic rst;

   rx_8b10b_align_decoder_if rx_if ();

   rx_8b10b_align_decoder #(.LOCK_COMMAS(2), .ERR_LIMIT(4)) dut (
      .i_Clk (clk),
      .i_Rst (rst),
      .rx    (rx_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_bad;

   // strobes seen during the last send_sym, and the fields of the last one
   int         stb_cnt;
   logic [7:0] cap_data;
   logic       cap_k;
   logic       cap_cerr;
   logic       cap_derr;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic d, input logic v, input logic re);
      rx_if.i_Ser_Data  = d;
      rx_if.i_Ser_Valid = v;
      rx_if.i_Realign   = re;
      @(posedge clk);
      #1;
      rx_if.i_Realign   = 1'b0;
      if (rx_if.o_Data_Valid === 1'b1) begin
         stb_cnt++;
         cap_data = rx_if.o_Data;
         cap_k    = rx_if.o_K;
         cap_cerr = rx_if.o_Code_Err;
         cap_derr = rx_if.o_Disp_Err;
      end
   endtask

   task automatic send_sym(input logic [9:0] s, input logic gap);
      stb_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (gap) step(~s[i], 1'b0, 1'b0);
         step(s[i], 1'b1, 1'b0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rx_if.i_Ser_Data  = 1'b0;
      rx_if.i_Ser_Valid = 1'b0;
      rx_if.i_Realign   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic lock_up(input logic gap);
      send_sym(KM, gap);
      send_sym(KM, gap);
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      stb_cnt = 0;
      cap_data = '0; cap_k = 1'b0; cap_cerr = 1'b0; cap_derr = 1'b0;

      // ---- reset state and basic lock ----
      do_reset();
      chk_eq("rst_locked", rx_if.o_Locked, 1'b0);
      chk_eq("rst_dvld",   rx_if.o_Data_Valid, 1'b0);
      chk_eq("rst_rd",     rx_if.o_RD, 1'b0);
      chk_eq("rst_data",   rx_if.o_Data, 8'h00);
      send_sym(KM, 1'b0);
      chk_eq("c1_stb",    stb_cnt, 0);
      chk_eq("c1_locked", rx_if.o_Locked, 1'b0);
      send_sym(KM, 1'b0);
      chk_eq("c2_stb",    stb_cnt, 1);
      chk_eq("c2_data",   cap_data, 8'hBC);
      chk_eq("c2_k",      cap_k, 1'b1);
      chk_eq("c2_rd",     rx_if.o_RD, 1'b1);
      chk_eq("c2_locked", rx_if.o_Locked, 1'b1);
      chk_eq("c2_cerr",   cap_cerr, 1'b0);

      // ---- data decode and disparity error ----
      send_sym(D0P, 1'b0);
      chk_eq("d0p_stb",  stb_cnt, 1);
      chk_eq("d0p_data", cap_data, 8'h00);
      chk_eq("d0p_k",    cap_k, 1'b0);
      chk_eq("d0p_rd",   rx_if.o_RD, 1'b1);
      chk_eq("d0p_cerr", cap_cerr, 1'b0);
      chk_eq("d0p_derr", cap_derr, 1'b0);
      send_sym(D0M, 1'b0);
      chk_eq("d0m_stb",  stb_cnt, 1);
      chk_eq("d0m_derr", cap_derr, 1'b1);
      chk_eq("d0m_cerr", cap_cerr, 1'b0);
      chk_eq("d0m_data", cap_data, 8'h00);
      chk_eq("d0m_rd",   rx_if.o_RD, 1'b0);

      // ---- offset alignment: 3 stray bits before the commas ----
      do_reset();
      stb_cnt = 0;
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk_eq("off_pre_stb", stb_cnt, 0);
      lock_up(1'b0);
      chk_eq("off_locked", rx_if.o_Locked, 1'b1);
      chk_eq("off_c_data", cap_data, 8'hBC);
      send_sym(D0P, 1'b0);
      chk_eq("off_d1_stb",  stb_cnt, 1);
      chk_eq("off_d1_data", cap_data, 8'h00);
      chk_eq("off_d1_err",  {cap_cerr, cap_derr}, 2'b00);
      send_sym(D0P, 1'b0);
      chk_eq("off_d2_data", cap_data, 8'h00);
      chk_eq("off_d2_err",  {cap_cerr, cap_derr}, 2'b00);

      // ---- error counting and loss of lock ----
      do_reset();
      lock_up(1'b0);
      for (int i = 0; i < 3; i++) begin
         send_sym(BAD, 1'b0);
         chk_eq($sformatf("e3_cerr%0d", i),   cap_cerr, 1'b1);
         chk_eq($sformatf("e3_locked%0d", i), rx_if.o_Locked, 1'b1);
      end
      send_sym(D0P, 1'b0);
      chk_eq("clean_cerr",   cap_cerr, 1'b0);
      chk_eq("clean_derr",   cap_derr, 1'b0);
      chk_eq("clean_locked", rx_if.o_Locked, 1'b1);
      for (int i = 0; i < 3; i++) begin
         send_sym(BAD, 1'b0);
         chk_eq($sformatf("e4_locked%0d", i), rx_if.o_Locked, 1'b1);
      end
      send_sym(BAD, 1'b0);
      chk_eq("e4_stb",    stb_cnt, 1);
      chk_eq("e4_cerr",   cap_cerr, 1'b1);
      chk_eq("e4_data",   cap_data, 8'h00);
      chk_eq("e4_locked", rx_if.o_Locked, 1'b0);

      // ---- gapped valid: same result as continuous ----
      do_reset();
      lock_up(1'b1);
      chk_eq("gap_locked", rx_if.o_Locked, 1'b1);
      chk_eq("gap_c_stb",  stb_cnt, 1);
      send_sym(D0P, 1'b1);
      chk_eq("gap_d_stb",  stb_cnt, 1);
      chk_eq("gap_d_data", cap_data, 8'h00);
      chk_eq("gap_d_rd",   rx_if.o_RD, 1'b1);
      send_sym(D0M, 1'b1);
      chk_eq("gap_m_derr", cap_derr, 1'b1);
      chk_eq("gap_m_stb",  stb_cnt, 1);

      // ---- reset mid-symbol ----
      do_reset();
      lock_up(1'b0);
      stb_cnt = 0;
      for (int i = 0; i < 5; i++) step(D0P[i], 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      chk_eq("mrst_locked", rx_if.o_Locked, 1'b0);
      chk_eq("mrst_dvld",   rx_if.o_Data_Valid, 1'b0);
      chk_eq("mrst_rd",     rx_if.o_RD, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_sym(KM, 1'b0);
      chk_eq("mrst_c1_locked", rx_if.o_Locked, 1'b0);
      send_sym(KM, 1'b0);
      chk_eq("mrst_c2_locked", rx_if.o_Locked, 1'b1);

      // ---- realign on the boundary bit ----
      stb_cnt = 0;
      for (int i = 0; i < 9; i++) step(D0P[i], 1'b1, 1'b0);
      step(D0P[9], 1'b1, 1'b1);
      chk_eq("ra_stb",    stb_cnt, 0);
      chk_eq("ra_locked", rx_if.o_Locked, 1'b0);
      chk_eq("ra_rd",     rx_if.o_RD, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk_eq("ra_dvld",   rx_if.o_Data_Valid, 1'b0);
      send_sym(KM, 1'b0);
      chk_eq("ra_c1_locked", rx_if.o_Locked, 1'b0);
      send_sym(KM, 1'b0);
      chk_eq("ra_c2_locked", rx_if.o_Locked, 1'b1);
      chk_eq("ra_c2_data",   cap_data, 8'hBC);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
